cell_tester: RTL and testbench

CELL_TESTER -- requirements
Module: cell_tester

---
 rtl/cell_tester.sv | 176 +++++++++++++++++
 tb/tb_cell_tester.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_tester.sv
// Automatic functional tester for a small library of standard cells (buf1, inv1, na21, dff1_r).
// Steps four stimulus vectors through the selected cell and reports per-vector failures.
module cell_tester #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] SEL,
    output logic       DUT_A,
    output logic       DUT_B,
    output logic       DUT_D,
    output logic       DUT_CLK,
    input  logic       DUT_Y,
    input  logic       DUT_Q,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERRCNT,
    output logic [3:0] FAIL_VEC
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE_H,
        CLKLO,
        SETTLE_L,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [1:0] SEL_DFF    = 2'd3;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] v_q, v_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] errcnt_q, errcnt_d;
    logic [3:0] failvec_q, failvec_d;
    logic       pass_q, pass_d;
    logic [3:0] stim_q, stim_d;
    logic       response;
    logic       expected;

    // Packed as {A, B, D, CLK}; the flop gets its clock raised together with D,
    // so D is long stable by the time the falling capture edge arrives.
    function automatic logic [3:0] stimFor(input logic [1:0] sel, input logic [1:0] v);
        if (sel == SEL_DFF) begin
            return {2'b00, v[1] ^ v[0], 1'b1};
        end
        return {v[1], v[0], 2'b00};
    endfunction

    function automatic logic expectFor(input logic [1:0] sel, input logic [1:0] v);
        case (sel)
            2'd0:    return v[1];
            2'd1:    return ~v[1];
            2'd2:    return ~(v[1] & v[0]);
            default: return v[1] ^ v[0];
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            v_q       <= 2'd0;
            cnt_q     <= 4'd0;
            errcnt_q  <= 3'd0;
            failvec_q <= 4'd0;
            pass_q    <= 1'b0;
            stim_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            errcnt_q  <= errcnt_d;
            failvec_q <= failvec_d;
            pass_q    <= pass_d;
            stim_q    <= stim_d;
        end
    end

    assign response = (sel_q == SEL_DFF) ? DUT_Q : DUT_Y;
    assign expected = expectFor(sel_q, v_q);

    // Stimulus registers are only rewritten on entry to APPLY, CLKLO and FINISH.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        errcnt_d  = errcnt_q;
        failvec_d = failvec_q;
        pass_d    = pass_q;
        stim_d    = stim_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    errcnt_d  = 3'd0;
                    failvec_d = 4'd0;
                    pass_d    = 1'b0;
                    sel_d     = SEL;
                    v_d       = 2'd0;
                    stim_d    = stimFor(SEL, 2'd0);
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                cnt_d   = SETTLE_CNT;
                state_d = SETTLE_H;
            end
            SETTLE_H: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    if (sel_q == SEL_DFF) begin
                        stim_d[0] = 1'b0;
                        state_d   = CLKLO;
                    end else begin
                        state_d = SAMPLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CLKLO: begin
                cnt_d   = SETTLE_CNT;
                state_d = SETTLE_L;
            end
            SETTLE_L: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                // Case inequality so an X or Z response counts as a miscompare.
                if (response !== expected) begin
                    if (errcnt_q != 3'd4) begin
                        errcnt_d = errcnt_q + 3'd1;
                    end
                    failvec_d[v_q] = 1'b1;
                end
                if (v_q == 2'd3) begin
                    pass_d  = (errcnt_d == 3'd0);
                    stim_d  = 4'd0;
                    state_d = FINISH;
                end else begin
                    v_d     = v_q + 2'd1;
                    stim_d  = stimFor(sel_q, v_q + 2'd1);
                    state_d = APPLY;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {DUT_A, DUT_B, DUT_D, DUT_CLK} = stim_q;
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == FINISH);
    assign PASS     = pass_q;
    assign ERRCNT   = errcnt_q;
    assign FAIL_VEC = failvec_q;

endmodule

// File: tb/tb_cell_tester.sv
// Directed bench for cell_tester: behavioural cell models feed two tester instances
// (SETTLE=2 and SETTLE=1) and each result is checked against hand-computed values.
module tb_cell_tester;

    logic       clk;
    logic       rst;
    logic       startA, startB;
    logic [1:0] sel;

    logic       aA, bA, dA, ckA, yA, qA, busyA, doneA, passA;
    logic [2:0] errA;
    logic [3:0] fvA;
    logic       aB, bB, dB, ckB, yB, qB, busyB, doneB, passB;
    logic [2:0] errB;
    logic [3:0] fvB;

    logic [1:0] cellSel;
    logic       yTie0;
    logic       useBadFlop;
    logic       goodQA = 1'b0;
    logic       badQA  = 1'b0;
    logic       dSampA = 1'b0;
    logic       goodQB = 1'b0;

    int vecCount  = 0;
    int missCount = 0;
    int cyc, ckHigh;
    int doneCount, idleCount, firstDone, secondDone, thirdDone;
    bit sawDone;

    cell_tester #(.SETTLE(2)) dutA (
        .CLK(clk), .RST(rst), .START(startA), .SEL(sel),
        .DUT_A(aA), .DUT_B(bA), .DUT_D(dA), .DUT_CLK(ckA),
        .DUT_Y(yA), .DUT_Q(qA),
        .BUSY(busyA), .DONE(doneA), .PASS(passA), .ERRCNT(errA), .FAIL_VEC(fvA)
    );

    cell_tester #(.SETTLE(1)) dutB (
        .CLK(clk), .RST(rst), .START(startB), .SEL(sel),
        .DUT_A(aB), .DUT_B(bB), .DUT_D(dB), .DUT_CLK(ckB),
        .DUT_Y(yB), .DUT_Q(qB),
        .BUSY(busyB), .DONE(doneB), .PASS(passB), .ERRCNT(errB), .FAIL_VEC(fvB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational cell models, or a stuck-at-0 output when yTie0 is set.
    assign yA = yTie0 ? 1'b0 :
                (cellSel == 2'd0) ? aA :
                (cellSel == 2'd1) ? ~aA : ~(aA & bA);
    assign yB = 1'b0;

    // Correct dff1_r captures on the falling DUT_CLK edge; the faulty one captures on
    // the rising edge and, since D moves with that edge, sees the previous D.
    always @(negedge ckA) goodQA <= dA;
    always @(negedge clk) dSampA = dA;
    always @(posedge ckA) badQA <= dSampA;
    always @(negedge ckB) goodQB <= dB;
    assign qA = useBadFlop ? badQA : goodQA;
    assign qB = goodQB;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulses START on one instance, then counts cycles until DONE (0 on timeout).
    // At pokeCycle it re-asserts START and changes SEL mid-run.
    task automatic applyStimulus(input bit onB, input int limit, input int pokeCycle,
                                 output int cycles, output int clkHigh);
        cycles  = 0;
        clkHigh = 0;
        if (onB) startB = 1'b1; else startA = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) begin
                startA = 1'b0;
                startB = 1'b0;
            end
            if (k == pokeCycle) begin
                if (onB) startB = 1'b1; else startA = 1'b1;
                sel = 2'd1;
            end
            if (k == pokeCycle + 1) begin
                startA = 1'b0;
                startB = 1'b0;
            end
            if (onB ? ckB : ckA) clkHigh++;
            if (onB ? doneB : doneA) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; startA = 1'b0; startB = 1'b0; sel = 2'd0;
        cellSel = 2'd0; yTie0 = 1'b0; useBadFlop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busyA, 0);
        checkOutput("reset_done", doneA, 0);
        checkOutput("reset_pass", passA, 0);
        checkOutput("reset_errcnt", errA, 0);
        checkOutput("reset_failvec", fvA, 0);
        checkOutput("reset_stim", {aA, bA, dA, ckA}, 0);
        checkOutput("reset_busyB", busyB, 0);
        rst = 1'b0;
        @(negedge clk);

        // Good na21.
        sel = 2'd2; cellSel = 2'd2;
        applyStimulus(1'b0, 60, 0, cyc, ckHigh);
        checkOutput("na21_latency", cyc, 17);
        checkOutput("na21_pass", passA, 1);
        checkOutput("na21_errcnt", errA, 0);
        checkOutput("na21_failvec", fvA, 0);
        checkOutput("na21_busy_at_done", busyA, 1);
        checkOutput("na21_clk_high", ckHigh, 0);
        @(negedge clk);
        checkOutput("na21_done_pulse", doneA, 0);
        checkOutput("na21_idle_busy", busyA, 0);
        checkOutput("na21_pass_held", passA, 1);

        // inv1 with output stuck at 0.
        sel = 2'd1; cellSel = 2'd1; yTie0 = 1'b1;
        applyStimulus(1'b0, 60, 0, cyc, ckHigh);
        checkOutput("inv_stuck_latency", cyc, 17);
        checkOutput("inv_stuck_pass", passA, 0);
        checkOutput("inv_stuck_errcnt", errA, 2);
        checkOutput("inv_stuck_failvec", fvA, 4'b0011);
        yTie0 = 1'b0;
        @(negedge clk);

        // Good buf1; START and SEL disturbed mid-run must not matter.
        sel = 2'd0; cellSel = 2'd0;
        applyStimulus(1'b0, 60, 5, cyc, ckHigh);
        checkOutput("buf_poke_latency", cyc, 17);
        checkOutput("buf_poke_pass", passA, 1);
        checkOutput("buf_poke_errcnt", errA, 0);
        sel = 2'd0;
        @(negedge clk);

        // Rising-edge flop in place of dff1_r.
        sel = 2'd3; useBadFlop = 1'b1;
        applyStimulus(1'b0, 60, 0, cyc, ckHigh);
        checkOutput("badff_latency", cyc, 29);
        checkOutput("badff_pass", passA, 0);
        checkOutput("badff_errcnt", errA, 2);
        checkOutput("badff_failvec", fvA, 4'b1010);
        checkOutput("badff_clk_high", ckHigh, 12);
        repeat (5) @(negedge clk);
        checkOutput("badff_failvec_held", fvA, 4'b1010);
        checkOutput("badff_errcnt_held", errA, 2);
        checkOutput("badff_pass_held", passA, 0);
        useBadFlop = 1'b0;

        // Good dff1_r on both settle lengths.
        applyStimulus(1'b0, 60, 0, cyc, ckHigh);
        checkOutput("dff_s2_latency", cyc, 29);
        checkOutput("dff_s2_pass", passA, 1);
        checkOutput("dff_s2_failvec", fvA, 0);
        @(negedge clk);
        applyStimulus(1'b1, 60, 0, cyc, ckHigh);
        checkOutput("dff_s1_latency", cyc, 21);
        checkOutput("dff_s1_clk_high", ckHigh, 8);
        checkOutput("dff_s1_pass", passB, 1);
        checkOutput("dff_s1_errcnt", errB, 0);
        checkOutput("dff_s1_failvec", fvB, 0);
        @(negedge clk);

        // Reset in cycle 5 of a buf1 run, with START asserted alongside it.
        sel = 2'd0; cellSel = 2'd0; sawDone = 1'b0;
        startA = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) startA = 1'b0;
            if (doneA) sawDone = 1'b1;
        end
        rst = 1'b1; startA = 1'b1;
        @(negedge clk);
        checkOutput("abort_no_done", sawDone, 0);
        checkOutput("abort_busy", busyA, 0);
        checkOutput("abort_done", doneA, 0);
        checkOutput("abort_pass", passA, 0);
        checkOutput("abort_errcnt", errA, 0);
        checkOutput("abort_stim", {aA, bA, dA, ckA}, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 60, 0, cyc, ckHigh);
        checkOutput("restart_latency", cyc, 17);
        checkOutput("restart_pass", passA, 1);
        @(negedge clk);

        // START held for 40 cycles: back-to-back runs with one IDLE cycle between.
        doneCount = 0; idleCount = 0; firstDone = 0; secondDone = 0; thirdDone = 0;
        startA = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) sel = 2'd3;
            if (k == 12) sel = 2'd0;
            if (doneA) begin
                doneCount++;
                if (doneCount == 1) firstDone = k; else secondDone = k;
                checkOutput("held_run_pass", passA, 1);
            end
            if (!busyA) idleCount++;
        end
        startA = 1'b0;
        for (int k = 41; k <= 100; k++) begin
            @(negedge clk);
            if (doneA) begin
                thirdDone = k;
                break;
            end
        end
        checkOutput("held_done_count", doneCount, 2);
        checkOutput("held_first_done", firstDone, 17);
        checkOutput("held_second_done", secondDone, 35);
        checkOutput("held_idle_cycles", idleCount, 2);
        checkOutput("held_third_done", thirdDone, 53);
        checkOutput("held_third_pass", passA, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
